// File: rtl/md5_sched_pkg.sv
// Shared types and constants for the md5 search scheduler.
package md5_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam int unsigned ELAPSED_W  = 40;

endpackage

// File: rtl/md5_search_sched_if.sv
// Scheduler <-> md5 core bank bus: candidates out, hashes with echoed candidates back.
interface md5_search_sched_if #(
  parameter int unsigned NUM_CORES = 3,
  parameter int unsigned ATT_W     = 64
);
  logic [NUM_CORES*ATT_W-1:0] att_bus;
  logic [NUM_CORES-1:0]       att_valid;
  logic [NUM_CORES*128-1:0]   hash_bus;
  logic [NUM_CORES*ATT_W-1:0] hash_att_bus;

  modport master (
    output att_bus, att_valid,
    input  hash_bus, hash_att_bus
  );

  modport slave (
    input  att_bus, att_valid,
    output hash_bus, hash_att_bus
  );
endinterface

// File: rtl/ascii_dec_add.sv
// Combinational add of a small constant (1..9) to an ASCII decimal string, LSB digit in byte 0.
module ascii_dec_add
  import md5_sched_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic [8*DIGITS-1:0] val_i,
  input  logic [3:0]          inc_i,
  output logic [8*DIGITS-1:0] sum_o,
  output logic                carry_o
);

  logic [7:0] d;
  logic [7:0] c;

  always_comb begin
    sum_o = '0;
    d     = '0;
    c     = {4'b0, inc_i};
    for (int i = 0; i < DIGITS; i++) begin
      d = val_i[i*8 +: 8] - ASCII_ZERO + c;
      if (d > 8'd9) begin
        sum_o[i*8 +: 8] = d - 8'd10 + ASCII_ZERO;
        c               = 8'd1;
      end else begin
        sum_o[i*8 +: 8] = d + ASCII_ZERO;
        c               = 8'd0;
      end
    end
    carry_o = (c != 8'd0);
  end

endmodule

// File: rtl/md5_search_sched.sv
// Candidate generator and match qualifier for a bank of pipelined md5 cores.
// Optional elapsed-cycle counter enabled by defining MD5_SCHED_CYCLE_CNT_EN.
module md5_search_sched
  import md5_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES = 3,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned PIPE_LAT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [127:0]          target_hash_i,
  md5_search_sched_if.master    core_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  found_o,
  output logic [8*DIGITS-1:0]   ans_pwd_o,
  output logic [ELAPSED_W-1:0]  elapsed_cycles_o
);

  localparam int unsigned ATT_W  = 8 * DIGITS;
  localparam int unsigned CandW  = NUM_CORES * ATT_W;
  localparam int unsigned PipeW  = PIPE_LAT * NUM_CORES;
  localparam int unsigned DrainW = $clog2(PIPE_LAT + 1);

  sched_state_e         state_q;
  logic [CandW-1:0]     cand_q, cand_nxt, cand_idle, cand_sum;
  logic [NUM_CORES-1:0] valid_q, valid_nxt, carry, hit, tap;
  logic [PipeW-1:0]     pipe_q, pipe_shift;
  logic [DrainW-1:0]    drain_q;
  logic                 found_q;
  logic [ATT_W-1:0]     ans_q, match_att;
  logic                 match_any;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_add
    ascii_dec_add #(
      .DIGITS (DIGITS)
    ) u_add (
      .val_i   (cand_q[k*ATT_W +: ATT_W]),
      .inc_i   (4'(NUM_CORES)),
      .sum_o   (cand_sum[k*ATT_W +: ATT_W]),
      .carry_o (carry[k])
    );
  end

  // Oldest slice of the valid pipe lines up with the hash leaving each core.
  assign tap        = pipe_q[PipeW-1 -: NUM_CORES];
  assign pipe_shift = PipeW'({pipe_q, valid_q});
  assign valid_nxt  = valid_q & ~carry;
  assign match_any  = |hit;

  always_comb begin
    cand_idle = {(NUM_CORES*DIGITS){ASCII_ZERO}};
    cand_nxt  = cand_q;
    hit       = '0;
    match_att = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idle[k*ATT_W +: 8] = ASCII_ZERO + 8'(k);
      if (valid_q[k] && !carry[k]) begin
        cand_nxt[k*ATT_W +: ATT_W] = cand_sum[k*ATT_W +: ATT_W];
      end
      hit[k] = tap[k] && (core_if.hash_bus[k*128 +: 128] == target_hash_i);
    end
    // Scan downwards so the lowest matching core index wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        match_att = core_if.hash_att_bus[k*ATT_W +: ATT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cand_q  <= {(NUM_CORES*DIGITS){ASCII_ZERO}};
      valid_q <= '0;
      pipe_q  <= '0;
      drain_q <= '0;
      found_q <= 1'b0;
      ans_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cand_q  <= cand_idle;
          valid_q <= '0;
          pipe_q  <= '0;
          if (start_i) begin
            state_q <= StRun;
            valid_q <= '1;
          end
        end
        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            pipe_q  <= '0;
          end else if (match_any) begin
            state_q <= StDone;
            found_q <= 1'b1;
            ans_q   <= match_att;
            valid_q <= '0;
            pipe_q  <= '0;
          end else begin
            cand_q  <= cand_nxt;
            valid_q <= valid_nxt;
            pipe_q  <= pipe_shift;
            if (valid_nxt == '0) begin
              state_q <= StDrain;
              drain_q <= '0;
            end
          end
        end
        StDrain: begin
          if (abort_i) begin
            state_q <= StIdle;
            pipe_q  <= '0;
          end else if (match_any) begin
            state_q <= StDone;
            found_q <= 1'b1;
            ans_q   <= match_att;
            pipe_q  <= '0;
          end else begin
            pipe_q <= pipe_shift;
            if (drain_q == DrainW'(PIPE_LAT)) begin
              state_q <= StDone;
            end else begin
              drain_q <= drain_q + DrainW'(1);
            end
          end
        end
        StDone: begin
          if (start_i) begin
            state_q <= StIdle;
            found_q <= 1'b0;
            ans_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_if.att_bus   = cand_q;
  assign core_if.att_valid = valid_q;
  assign busy_o            = (state_q == StRun) || (state_q == StDrain);
  assign done_o            = (state_q == StDone);
  assign found_o           = found_q;
  assign ans_pwd_o         = ans_q;

`ifdef MD5_SCHED_CYCLE_CNT_EN
  logic [ELAPSED_W-1:0] elapsed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elapsed_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      elapsed_q <= '0;
    end else if (busy_o && (elapsed_q != '1)) begin
      elapsed_q <= elapsed_q + ELAPSED_W'(1);
    end
  end

  assign elapsed_cycles_o = elapsed_q;
`else
  assign elapsed_cycles_o = '0;
`endif

endmodule

// File: tb/tb_md5_search_sched.sv
// Bench for md5_search_sched with 4-cycle stub cores returning hash = {zero pad, att}.
module tb_md5_search_sched;

  localparam int NC   = 3;
  localparam int DG   = 3;
  localparam int PL   = 4;
  localparam int AW   = 8 * DG;
  localparam int LAST = 999;
  localparam logic [127:0] NOMATCH = {16'hffff, 112'h0};

  typedef struct {
    logic [127:0] t_hash;
    bit           m_found;
    int           m_done;
    logic [23:0]  m_ans;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [127:0]  tgt;
  logic          busy, done, found;
  logic [AW-1:0] ans;
  logic [39:0]   elapsed;
  logic [NC-1:0] force_mask;
  logic [3:0][NC*AW-1:0] dly = '0;
  logic [AW-1:0] last_att [NC];
  int            n_chk  = 0;
  int            n_fail = 0;
  vec_t          tbl [7];

  md5_search_sched_if #(.NUM_CORES(NC), .ATT_W(AW)) cif ();

  md5_search_sched #(
    .NUM_CORES (NC),
    .DIGITS    (DG),
    .PIPE_LAT  (PL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start),
    .abort_i          (abort),
    .target_hash_i    (tgt),
    .core_if          (cif.master),
    .busy_o           (busy),
    .done_o           (done),
    .found_o          (found),
    .ans_pwd_o        (ans),
    .elapsed_cycles_o (elapsed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[2:0], cif.att_bus};
  assign cif.hash_att_bus = dly[3];

  always_comb begin
    cif.hash_bus = '0;
    for (int k = 0; k < NC; k++) begin
      cif.hash_bus[k*128 +: 128] = force_mask[k] ? tgt : {104'b0, dly[3][k*AW +: AW]};
    end
  end

  function automatic logic [23:0] asc(input int v);
    logic [23:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[i*8 +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] exp_el(input int d);
    logic [39:0] r;
    r = 40'(d);
`ifndef MD5_SCHED_CYCLE_CNT_EN
    r = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range();
    logic ok;
    logic [7:0] b;
    ok = 1'b1;
    for (int i = 0; i < NC * DG; i++) begin
      b = cif.att_bus[i*8 +: 8];
      if (b < 8'h30 || b > 8'h39) ok = 1'b0;
    end
    chk("att_digit_range", 128'(ok), 128'(1'b1));
  endtask

  task automatic chk_reset();
    chk("rst_att_bus", 128'(cif.att_bus), 128'({(NC*DG){8'h30}}));
    chk("rst_att_valid", 128'(cif.att_valid), 128'(0));
    chk("rst_flags", 128'({busy, done, found}), 128'(0));
    chk("rst_ans", 128'(ans), 128'(0));
    chk("rst_elapsed", 128'(elapsed), 128'(0));
  endtask

  // Expects to be called at the sampling point of RUN cycle 0.
  task automatic check_run(input bit ef, input int ed, input logic [23:0] ea);
    int v;
    for (int c = 0; c <= ed; c++) begin
      chk_range();
      if (c < ed) begin
        chk("run_flags", 128'({busy, done, found}), 128'(3'b100));
        for (int k = 0; k < NC; k++) begin
          v = k + NC * c;
          chk("att_valid", 128'(cif.att_valid[k]), 128'(v <= LAST));
          if (v <= LAST) chk("att_value", 128'(cif.att_bus[k*AW +: AW]), 128'(asc(v)));
          if (cif.att_valid[k]) last_att[k] = cif.att_bus[k*AW +: AW];
        end
        start = (c == 10) && (ed > 12);
        @(negedge clk);
      end else begin
        chk("done_flags", 128'({busy, done, found}), 128'({2'b01, ef}));
        chk("done_att_valid", 128'(cif.att_valid), 128'(0));
        chk("ans_pwd", 128'(ans), 128'(ea));
        chk("elapsed", 128'(elapsed), 128'(exp_el(ed)));
      end
    end
    @(negedge clk);
    chk("done_hold", 128'({done, found}), 128'({1'b1, ef}));
    chk("ans_hold", 128'(ans), 128'(ea));
    chk("elapsed_hold", 128'(elapsed), 128'(exp_el(ed)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("back_to_idle", 128'({busy, done, found}), 128'(0));
  endtask

  task automatic run_search(input logic [127:0] t, input bit ef, input int ed,
                            input logic [23:0] ea);
    tgt   = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_run(ef, ed, ea);
  endtask

  initial begin
    int v;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    force_mask = '0;
    tgt        = '0;
    for (int k = 0; k < NC; k++) last_att[k] = '0;

    tbl[0] = '{t_hash: {104'b0, 24'h343137}, m_found: 1'b1, m_done: 144, m_ans: 24'h343137};
    tbl[1] = '{t_hash: {104'b0, 24'h303030}, m_found: 1'b1, m_done: 5,   m_ans: 24'h303030};
    tbl[2] = '{t_hash: {104'b0, 24'h303032}, m_found: 1'b1, m_done: 5,   m_ans: 24'h303032};
    tbl[3] = '{t_hash: {104'b0, 24'h353030}, m_found: 1'b1, m_done: 171, m_ans: 24'h353030};
    tbl[4] = '{t_hash: {104'b0, 24'h393938}, m_found: 1'b1, m_done: 337, m_ans: 24'h393938};
    tbl[5] = '{t_hash: {104'b0, 24'h393939}, m_found: 1'b1, m_done: 338, m_ans: 24'h393939};
    tbl[6] = '{t_hash: NOMATCH,              m_found: 1'b0, m_done: 339, m_ans: 24'h0};

    @(negedge clk);
    @(negedge clk);
    chk_reset();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_load", 128'(cif.att_bus), 128'({asc(2), asc(1), asc(0)}));

    for (int i = 0; i < 7; i++) begin
      run_search(tbl[i].t_hash, tbl[i].m_found, tbl[i].m_done, tbl[i].m_ans);
      if (!tbl[i].m_found) begin
        chk("last_core0", 128'(last_att[0]), 128'(asc(999)));
        chk("last_core1", 128'(last_att[1]), 128'(asc(997)));
        chk("last_core2", 128'(last_att[2]), 128'(asc(998)));
      end
    end

    // Random targets: candidate v is issued by core v%NC at RUN cycle v/NC.
    for (int i = 0; i < 4; i++) begin
      v = int'($urandom_range(999, 0));
      run_search({104'b0, asc(v)}, 1'b1, v / NC + PL + 1, asc(v));
    end

    // Abort (with start) in RUN after the target was issued, then restart immediately.
    tgt   = {104'b0, asc(147)};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_abort_busy", 128'(busy), 128'(1'b1));
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_flags", 128'({busy, done, found}), 128'(0));
    chk("abort_valid", 128'(cif.att_valid), 128'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_att", 128'(cif.att_bus), 128'({asc(2), asc(1), asc(0)}));
    check_run(1'b1, 147 / NC + PL + 1, asc(147));

    // Cores 1 and 2 report a match in the same cycle.
    tgt   = NOMATCH;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    force_mask = 3'b110;
    @(negedge clk);
    force_mask = '0;
    chk("sim_flags", 128'({busy, done, found}), 128'(3'b011));
    chk("sim_ans", 128'(ans), 128'(asc(1 + NC * (20 - PL))));
    chk("sim_elapsed", 128'(elapsed), 128'(exp_el(21)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset during DRAIN while core 0's "999" match is still in flight.
    tgt   = {104'b0, asc(999)};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (335) @(negedge clk);
    chk("drain_busy", 128'({busy, done}), 128'(2'b10));
    reset = 1'b1;
    #1;
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 128'({busy, done, found}), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
